exec_commit_stage: RTL and testbench

EXEC_COMMIT_STAGE -- requirements
Module: exec_commit_stage

---
 rtl/exec_commit_stage.sv | 136 +++++++++++++
 tb/tb_exec_commit_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/exec_commit_stage.sv
// exec_commit_stage: EX/commit pipeline register with architectural C/Z flags.
// Captures ID/EX control and ALU results, applies conditional-cancel, tracks
// flags (EX update beats the older memory-stage Z update) and flags writes to
// the PC (register all-ones) with a one-cycle redirect pulse.
// Optional perf counters are enabled by defining EXEC_COMMIT_PERF_CNT_EN.
module exec_commit_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic               in_c_wr,
  input  logic               in_z_wr,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_modify_reg_write,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_z_wr,
  input  logic               mem_z,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_result,
  output logic [DATA_W-1:0]  out_pc,
  output logic [RADDR_W-1:0] out_dest,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic               carry_flag,
  output logic               zero_flag,
`ifdef EXEC_COMMIT_PERF_CNT_EN
  output logic [DATA_W-1:0]  perf_commit,
  output logic [DATA_W-1:0]  perf_cancel,
`endif
  output logic               pc_redirect
);

  logic               r_valid, r_reg_write, r_mem_read, r_mem_write;
  logic [DATA_W-1:0]  r_result, r_pc;
  logic [RADDR_W-1:0] r_dest;
  logic               r_carry, r_zero, r_redirect;

  logic w_cap, w_kill, w_reg_write, w_mem_write, w_mem_read;
  logic w_c_upd, w_z_upd, w_redirect;

  // Decode capture/cancel and the enables the captured instruction produces
  always_comb begin
    w_cap       = ~stall & ~flush;
    w_kill      = in_valid & alu_modify_reg_write;
    w_reg_write = in_valid & in_reg_write & ~w_kill;
    w_mem_write = in_valid & in_mem_write & ~w_kill;
    w_mem_read  = in_valid & in_mem_read;
    w_c_upd     = w_cap & in_valid & in_c_wr & ~w_kill;
    w_z_upd     = w_cap & in_valid & in_z_wr & ~w_kill;
    w_redirect  = w_reg_write & (in_dest == {RADDR_W{1'b1}});
  end

  // Pipeline register: reset > flush (bubble) > stall (hold) > capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_result    <= '0;
      r_pc        <= '0;
      r_dest      <= '0;
      r_redirect  <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_redirect  <= 1'b0;
    end else if (stall) begin
      r_redirect  <= 1'b0;
    end else begin
      r_valid     <= in_valid;
      r_reg_write <= w_reg_write;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_result    <= alu_result;
      r_pc        <= in_pc;
      r_dest      <= in_dest;
      r_redirect  <= w_redirect;
    end
  end

  // Flags: C only from a live EX capture; Z from EX first, else memory stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      if (w_c_upd) r_carry <= alu_carry;
      if (w_z_upd)       r_zero <= alu_zero;
      else if (mem_z_wr) r_zero <= mem_z;
    end
  end

`ifdef EXEC_COMMIT_PERF_CNT_EN
  logic [DATA_W-1:0] r_perf_commit, r_perf_cancel;

  // Retire counters; natural wrap at the counter width
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_commit <= '0;
      r_perf_cancel <= '0;
    end else if (w_cap) begin
      if (in_valid & ~w_kill) r_perf_commit <= r_perf_commit + 1'b1;
      if (w_kill)             r_perf_cancel <= r_perf_cancel + 1'b1;
    end
  end

  assign perf_commit = r_perf_commit;
  assign perf_cancel = r_perf_cancel;
`endif

  assign out_valid     = r_valid;
  assign out_result    = r_result;
  assign out_pc        = r_pc;
  assign out_dest      = r_dest;
  assign out_reg_write = r_reg_write;
  assign out_mem_read  = r_mem_read;
  assign out_mem_write = r_mem_write;
  assign carry_flag    = r_carry;
  assign zero_flag     = r_zero;
  assign pc_redirect   = r_redirect;

endmodule

// File: tb/tb_exec_commit_stage.sv
// Directed bench for exec_commit_stage: reset, ADD, cancelled ADC, stall/flush,
// Z-flag priority, PC redirect and reset mid-sequence.
module tb_exec_commit_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_reg_write, in_mem_read, in_mem_write, in_c_wr, in_z_wr;
  logic [15:0] in_pc, alu_result;
  logic [2:0]  in_dest;
  logic        alu_carry, alu_zero, alu_modify_reg_write;
  logic        stall, flush, mem_z_wr, mem_z;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [15:0] out_result, out_pc;
  logic [2:0]  out_dest;
  logic        carry_flag, zero_flag, pc_redirect;
`ifdef EXEC_COMMIT_PERF_CNT_EN
  logic [15:0] perf_commit, perf_cancel;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exec_commit_stage #(.DATA_W(16), .RADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_pc(in_pc), .in_dest(in_dest),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_c_wr(in_c_wr), .in_z_wr(in_z_wr),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .alu_modify_reg_write(alu_modify_reg_write),
    .stall(stall), .flush(flush), .mem_z_wr(mem_z_wr), .mem_z(mem_z),
    .out_valid(out_valid), .out_result(out_result), .out_pc(out_pc),
    .out_dest(out_dest), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
`ifdef EXEC_COMMIT_PERF_CNT_EN
    .perf_commit(perf_commit), .perf_cancel(perf_cancel),
`endif
    .pc_redirect(pc_redirect)
  );

  task automatic idle();
    reset = 0; in_valid = 0; in_pc = 0; in_dest = 0; in_reg_write = 0;
    in_mem_read = 0; in_mem_write = 0; in_c_wr = 0; in_z_wr = 0;
    alu_result = 0; alu_carry = 0; alu_zero = 0; alu_modify_reg_write = 0;
    stall = 0; flush = 0; mem_z_wr = 0; mem_z = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1; in_valid = 1; in_reg_write = 1; in_dest = 3'd7;
    alu_result = 16'hBEEF; in_c_wr = 1; alu_carry = 1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
    n_cmp++; if (out_result !== 16'h0) begin n_bad++; $display("FAIL rst_result got %h exp 0000", out_result); end
    n_cmp++; if (out_reg_write !== 1'b0) begin n_bad++; $display("FAIL rst_regw got %0b exp 0", out_reg_write); end
    n_cmp++; if (carry_flag !== 1'b0 || zero_flag !== 1'b0) begin n_bad++; $display("FAIL rst_flags got C%0b Z%0b exp C0 Z0", carry_flag, zero_flag); end
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL rst_redirect got %0b exp 0", pc_redirect); end
  endtask

  task automatic test_add();
    idle(); in_valid = 1; in_pc = 16'h0010; in_dest = 3'd3; in_reg_write = 1;
    in_c_wr = 1; in_z_wr = 1; alu_result = 16'h0000; alu_carry = 1; alu_zero = 1;
    step();
    n_cmp++; if (out_result !== 16'h0000) begin n_bad++; $display("FAIL add_result got %h exp 0000", out_result); end
    n_cmp++; if (out_reg_write !== 1'b1 || out_valid !== 1'b1) begin n_bad++; $display("FAIL add_regw got v%0b w%0b exp v1 w1", out_valid, out_reg_write); end
    n_cmp++; if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin n_bad++; $display("FAIL add_flags got C%0b Z%0b exp C1 Z1", carry_flag, zero_flag); end
    n_cmp++; if (out_dest !== 3'd3 || out_pc !== 16'h0010) begin n_bad++; $display("FAIL add_fields got d%0d pc%h exp d3 pc0010", out_dest, out_pc); end
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL add_redirect got %0b exp 0", pc_redirect); end
  endtask

  task automatic test_cancel();
    idle(); in_valid = 1; in_dest = 3'd7; in_reg_write = 1; in_mem_write = 1;
    in_mem_read = 1; in_c_wr = 1; in_z_wr = 1; alu_result = 16'h5555;
    alu_carry = 0; alu_zero = 0; alu_modify_reg_write = 1;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL cancel_valid got %0b exp 1", out_valid); end
    n_cmp++; if (out_reg_write !== 1'b0 || out_mem_write !== 1'b0) begin n_bad++; $display("FAIL cancel_wen got rw%0b mw%0b exp 0 0", out_reg_write, out_mem_write); end
    n_cmp++; if (out_mem_read !== 1'b1) begin n_bad++; $display("FAIL cancel_mrd got %0b exp 1", out_mem_read); end
    n_cmp++; if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin n_bad++; $display("FAIL cancel_flags got C%0b Z%0b exp C1 Z1", carry_flag, zero_flag); end
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL cancel_redirect got %0b exp 0", pc_redirect); end
  endtask

  task automatic test_stall_flush();
    idle(); in_valid = 1; in_dest = 3'd2; in_reg_write = 1; in_c_wr = 1;
    alu_carry = 0; alu_result = 16'h1234;
    step();
    n_cmp++; if (out_result !== 16'h1234 || carry_flag !== 1'b0) begin n_bad++; $display("FAIL stall_pre got %h C%0b exp 1234 C0", out_result, carry_flag); end
    for (int i = 0; i < 3; i++) begin
      stall = 1; in_dest = 3'd7; alu_result = 16'hA000 + 16'(i); alu_carry = 1;
      in_z_wr = 1; alu_zero = 0; in_pc = 16'h0100;
      step();
      n_cmp++; if (out_result !== 16'h1234 || out_dest !== 3'd2 || out_reg_write !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d got %h d%0d w%0b exp 1234 d2 w1", i, out_result, out_dest, out_reg_write); end
      n_cmp++; if (carry_flag !== 1'b0 || zero_flag !== 1'b1 || pc_redirect !== 1'b0) begin n_bad++; $display("FAIL stall_flags%0d got C%0b Z%0b r%0b exp C0 Z1 r0", i, carry_flag, zero_flag, pc_redirect); end
    end
    flush = 1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin n_bad++; $display("FAIL flush_bubble got v%0b w%0b exp 0 0", out_valid, out_reg_write); end
    n_cmp++; if (out_result !== 16'h1234) begin n_bad++; $display("FAIL flush_data got %h exp 1234", out_result); end
    n_cmp++; if (carry_flag !== 1'b0 || zero_flag !== 1'b1) begin n_bad++; $display("FAIL flush_flags got C%0b Z%0b exp C0 Z1", carry_flag, zero_flag); end
    idle(); stall = 1; mem_z_wr = 1; mem_z = 0;
    step();
    n_cmp++; if (zero_flag !== 1'b0) begin n_bad++; $display("FAIL stall_memz got %0b exp 0", zero_flag); end
  endtask

  task automatic test_zero_priority();
    idle(); mem_z_wr = 1; mem_z = 1;
    step();
    n_cmp++; if (zero_flag !== 1'b1) begin n_bad++; $display("FAIL memz_set got %0b exp 1", zero_flag); end
    idle(); in_valid = 1; in_z_wr = 1; alu_zero = 0; mem_z_wr = 1; mem_z = 1;
    step();
    n_cmp++; if (zero_flag !== 1'b0) begin n_bad++; $display("FAIL zprio_ex got %0b exp 0", zero_flag); end
    idle(); mem_z_wr = 1; mem_z = 1; in_c_wr = 1; alu_carry = 1; in_reg_write = 1;
    step();
    n_cmp++; if (zero_flag !== 1'b1) begin n_bad++; $display("FAIL zprio_mem got %0b exp 1", zero_flag); end
    n_cmp++; if (carry_flag !== 1'b0 || out_valid !== 1'b0 || out_reg_write !== 1'b0) begin n_bad++; $display("FAIL invalid_cap got C%0b v%0b w%0b exp 0 0 0", carry_flag, out_valid, out_reg_write); end
  endtask

  task automatic test_redirect();
    idle(); in_valid = 1; in_dest = 3'd7; in_reg_write = 1; alu_result = 16'h0040;
    step();
    n_cmp++; if (pc_redirect !== 1'b1 || out_result !== 16'h0040) begin n_bad++; $display("FAIL redir_pulse got r%0b %h exp r1 0040", pc_redirect, out_result); end
    idle();
    step();
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL redir_drop got %0b exp 0", pc_redirect); end
    idle(); in_valid = 1; in_dest = 3'd7; in_reg_write = 0; alu_result = 16'h0080;
    step();
    n_cmp++; if (pc_redirect !== 1'b0) begin n_bad++; $display("FAIL redir_nowrite got %0b exp 0", pc_redirect); end
    idle(); in_valid = 1; in_dest = 3'd7; in_reg_write = 1; alu_result = 16'h0040;
    in_c_wr = 1; alu_carry = 1; mem_z_wr = 1; mem_z = 1; reset = 1;
    step();
    n_cmp++; if (pc_redirect !== 1'b0 || out_valid !== 1'b0 || out_reg_write !== 1'b0) begin n_bad++; $display("FAIL redir_reset got r%0b v%0b w%0b exp 0 0 0", pc_redirect, out_valid, out_reg_write); end
    n_cmp++; if (out_result !== 16'h0 || carry_flag !== 1'b0 || zero_flag !== 1'b0) begin n_bad++; $display("FAIL redir_reset_data got %h C%0b Z%0b exp 0000 C0 Z0", out_result, carry_flag, zero_flag); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_add();
    test_cancel();
    test_stall_flush();
    test_zero_priority();
    test_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
